// File: rtl/adc_config_sequencer.sv
// adc_config_sequencer: walks the init table into the ADC config port, then arbitrates host accesses.
// Optional readback verify with rewrite retries is enabled by defining ADC_SEQ_VERIFY_EN.
module adc_config_sequencer #(
    parameter int unsigned NUM_REGS       = 8,
    parameter logic [71:0] INIT_VALUES    = 72'h0,
    parameter int unsigned TIMEOUT_CYCLES = 8192,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reinit,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [2:0] host_addr,
    input  logic [8:0] host_wdata,
    output logic       host_ack,
    output logic [8:0] host_rdata,
    output logic       host_err,
    output logic       init_done,
    output logic       init_error,
    output logic [2:0] cfg_wr_addr,
    output logic [8:0] cfg_wr_data,
    output logic       cfg_wr_en,
    input  logic       cfg_wr_rdy,
    input  logic       cfg_wr_done,
    output logic [2:0] cfg_rd_addr,
    output logic       cfg_rd_en,
    input  logic       cfg_rd_rdy,
    input  logic       cfg_rd_done,
    input  logic [8:0] cfg_rd_data
);

    localparam logic [2:0]  LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
`ifdef ADC_SEQ_VERIFY_EN
        ST_VERIFY_ISSUE,
        ST_VERIFY_WAIT,
`endif
        ST_READY,
        ST_HOST_ISSUE,
        ST_HOST_WAIT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    state_t      adv_state;

    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [15:0] timer_q;
    logic [15:0] timer_d;
    logic        pend_q;
    logic        pend_d;

    logic        hwe_q;
    logic        hwe_d;
    logic [2:0]  haddr_q;
    logic [2:0]  haddr_d;
    logic [8:0]  hwdata_q;
    logic [8:0]  hwdata_d;

    logic        done_d;
    logic        err_d;
    logic        wr_en_d;
    logic [2:0]  wr_addr_d;
    logic [8:0]  wr_data_d;
    logic        rd_en_d;
    logic [2:0]  rd_addr_d;
    logic        ack_d;
    logic [8:0]  rdata_d;
    logic        herr_d;

    logic        adv;
    logic        timed_out;
    logic        last_entry;
    logic        host_rdy;
    logic        host_done;
    logic [8:0]  entry_val;

`ifdef ADC_SEQ_VERIFY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               rd_match;
    logic               retry_left;

    assign rd_match   = (cfg_rd_data == entry_val);
    assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));
`else
    logic [31:0] unused_max_retry;

    assign unused_max_retry = MAX_RETRY;
`endif

    assign timed_out  = (timer_q == TO_LAST);
    assign last_entry = (idx_q == LAST_IDX);
    assign adv_state  = last_entry ? ST_READY : ST_INIT_ISSUE;
    assign host_rdy   = hwe_q ? cfg_wr_rdy : cfg_rd_rdy;
    assign host_done  = hwe_q ? cfg_wr_done : cfg_rd_done;

    // Table lookup for the entry currently being written or verified
    always_comb begin
        entry_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (idx_q == 3'(i)) begin
                entry_val = INIT_VALUES[9*i +: 9];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: begin
                if (cfg_wr_rdy) begin
                    state_d = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (cfg_wr_done) begin
`ifdef ADC_SEQ_VERIFY_EN
                    state_d = ST_VERIFY_ISSUE;
`else
                    state_d = adv_state;
`endif
                end else if (timed_out) begin
                    state_d = adv_state;
                end
            end
`ifdef ADC_SEQ_VERIFY_EN
            ST_VERIFY_ISSUE: begin
                if (cfg_rd_rdy) begin
                    state_d = ST_VERIFY_WAIT;
                end
            end
            ST_VERIFY_WAIT: begin
                if (cfg_rd_done) begin
                    if (rd_match || !retry_left) begin
                        state_d = adv_state;
                    end else begin
                        state_d = ST_INIT_ISSUE;
                    end
                end else if (timed_out) begin
                    state_d = adv_state;
                end
            end
`endif
            ST_READY: begin
                if (pend_q || reinit) begin
                    state_d = ST_INIT_ISSUE;
                end else if (host_req && !host_ack) begin
                    state_d = ST_HOST_ISSUE;
                end
            end
            ST_HOST_ISSUE: begin
                if (host_rdy) begin
                    state_d = ST_HOST_WAIT;
                end
            end
            ST_HOST_WAIT: begin
                if (host_done || timed_out) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Next values for the registered outputs, table walk and host latch
    always_comb begin
        adv       = 1'b0;
        idx_d     = idx_q;
        timer_d   = '0;
        pend_d    = pend_q | (reinit & (state_q != ST_READY));
        done_d    = init_done;
        err_d     = init_error;
        hwe_d     = hwe_q;
        haddr_d   = haddr_q;
        hwdata_d  = hwdata_q;
        wr_en_d   = 1'b0;
        wr_addr_d = cfg_wr_addr;
        wr_data_d = cfg_wr_data;
        rd_en_d   = 1'b0;
        rd_addr_d = cfg_rd_addr;
        ack_d     = 1'b0;
        rdata_d   = host_rdata;
        herr_d    = 1'b0;
`ifdef ADC_SEQ_VERIFY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            ST_INIT_ISSUE: begin
                if (cfg_wr_rdy) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = entry_val;
                end
            end
            ST_INIT_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (cfg_wr_done) begin
`ifndef ADC_SEQ_VERIFY_EN
                    adv = 1'b1;
`endif
                end else if (timed_out) begin
                    err_d = 1'b1;
                    adv   = 1'b1;
                end
            end
`ifdef ADC_SEQ_VERIFY_EN
            ST_VERIFY_ISSUE: begin
                if (cfg_rd_rdy) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = idx_q;
                end
            end
            ST_VERIFY_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (cfg_rd_done) begin
                    if (rd_match) begin
                        adv = 1'b1;
                    end else if (retry_left) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                        adv   = 1'b1;
                    end
                end else if (timed_out) begin
                    err_d = 1'b1;
                    adv   = 1'b1;
                end
            end
`endif
            ST_READY: begin
                if (pend_q || reinit) begin
                    pend_d = 1'b0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idx_d  = '0;
                end else if (host_req && !host_ack) begin
                    hwe_d    = host_we;
                    haddr_d  = host_addr;
                    hwdata_d = host_wdata;
                end
            end
            ST_HOST_ISSUE: begin
                if (host_rdy) begin
                    if (hwe_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = haddr_q;
                        wr_data_d = hwdata_q;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = haddr_q;
                    end
                end
            end
            ST_HOST_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (host_done) begin
                    ack_d = 1'b1;
                    if (!hwe_q) begin
                        rdata_d = cfg_rd_data;
                    end
                end else if (timed_out) begin
                    ack_d  = 1'b1;
                    herr_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (adv) begin
`ifdef ADC_SEQ_VERIFY_EN
            retry_d = '0;
`endif
            if (last_entry) begin
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            hwe_q       <= 1'b0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
`ifdef ADC_SEQ_VERIFY_EN
            retry_q     <= '0;
`endif
        end else begin
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            hwe_q       <= hwe_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            init_done   <= done_d;
            init_error  <= err_d;
            cfg_wr_en   <= wr_en_d;
            cfg_wr_addr <= wr_addr_d;
            cfg_wr_data <= wr_data_d;
            cfg_rd_en   <= rd_en_d;
            cfg_rd_addr <= rd_addr_d;
            host_ack    <= ack_d;
            host_rdata  <= rdata_d;
            host_err    <= herr_d;
`ifdef ADC_SEQ_VERIFY_EN
            retry_q     <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_adc_config_sequencer.sv
// Scoreboard bench for adc_config_sequencer with a behavioural config-port controller.
// Expected cfg requests and host acks are queued by the stimulus and popped by the monitor.
`timescale 1ns/1ps
module tb_adc_config_sequencer;

    localparam logic [71:0] TABLE = {45'h0, 9'h003, 9'h0F0, 9'h1A5};

    typedef struct packed {
        logic [2:0] a;
        logic [8:0] d;
    } wr_t;

    typedef struct packed {
        logic       err;
        logic [8:0] rdata;
        logic [7:0] lat;
    } ack_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reinit;
    logic       host_req;
    logic       host_we;
    logic [2:0] host_addr;
    logic [8:0] host_wdata;
    logic       host_ack;
    logic [8:0] host_rdata;
    logic       host_err;
    logic       init_done;
    logic       init_error;
    logic [2:0] cfg_wr_addr;
    logic [8:0] cfg_wr_data;
    logic       cfg_wr_en;
    logic       cfg_wr_rdy = 1'b1;
    logic       cfg_wr_done = 1'b0;
    logic [2:0] cfg_rd_addr;
    logic       cfg_rd_en;
    logic       cfg_rd_rdy = 1'b1;
    logic       cfg_rd_done = 1'b0;
    logic [8:0] cfg_rd_data = '0;

    wr_t        exp_wr[$];
    logic [2:0] exp_rd[$];
    ack_t       exp_ack[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_en_cyc = 0;
    int wr_seen = 0;

    int lat = 20;
    bit drop = 1'b0;
    int bad_limit = 0;
    int bad_base = 0;
    int bad_seen = 0;
    bit b_busy = 1'b0;
    bit b_wr = 1'b0;
    int b_cnt = 0;
    logic [2:0] b_a = '0;
    logic [8:0] b_d = '0;
    logic [8:0] mem[8];

    adc_config_sequencer #(
        .NUM_REGS(3),
        .INIT_VALUES(TABLE),
        .TIMEOUT_CYCLES(64),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .reinit(reinit),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_ack(host_ack),
        .host_rdata(host_rdata),
        .host_err(host_err),
        .init_done(init_done),
        .init_error(init_error),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cfg_wr_en(cfg_wr_en),
        .cfg_wr_rdy(cfg_wr_rdy),
        .cfg_wr_done(cfg_wr_done),
        .cfg_rd_addr(cfg_rd_addr),
        .cfg_rd_en(cfg_rd_en),
        .cfg_rd_rdy(cfg_rd_rdy),
        .cfg_rd_done(cfg_rd_done),
        .cfg_rd_data(cfg_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: got an event expected none", name);
    endtask

    function automatic logic [31:0] outs();
        return 32'({cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
                    host_ack, host_rdata, host_err, init_done, init_error});
    endfunction

    // Controller model: accepts one request, answers after lat cycles
    always @(negedge clk) begin
        cfg_wr_done = 1'b0;
        cfg_rd_done = 1'b0;
        if (!reset_n) begin
            b_busy = 1'b0;
            for (int i = 0; i < 8; i++) mem[i] = '0;
            mem[5] = 9'h155;
        end else if (cfg_wr_en) begin
            b_busy = 1'b1; b_wr = 1'b1; b_cnt = lat;
            b_a = cfg_wr_addr; b_d = cfg_wr_data;
        end else if (cfg_rd_en) begin
            b_busy = 1'b1; b_wr = 1'b0; b_cnt = lat;
            b_a = cfg_rd_addr;
        end else if (b_busy) begin
            if (b_cnt > 1) begin
                b_cnt--;
            end else begin
                b_busy = 1'b0;
                if (!drop) begin
                    if (b_wr) begin
                        mem[b_a] = b_d;
                        cfg_wr_done = 1'b1;
                    end else begin
                        cfg_rd_data = mem[b_a];
                        if (b_a == 3'd1) begin
                            if (bad_seen - bad_base < bad_limit) cfg_rd_data = 9'h0F1;
                            bad_seen++;
                        end
                        cfg_rd_done = 1'b1;
                    end
                end
            end
        end
        cfg_wr_rdy = !b_busy;
        cfg_rd_rdy = !b_busy;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a request or ack
    always @(negedge clk) begin
        wr_t  w;
        ack_t k;
        logic [2:0] r;
        if (reset_n) begin
            if (cfg_wr_en && cfg_rd_en) note_fail("en_overlap");
            if (cfg_wr_en) begin
                last_en_cyc = cyc;
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    note_fail("wr_unexpected");
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(cfg_wr_addr), 32'(w.a));
                    check("wr_data", 32'(cfg_wr_data), 32'(w.d));
                end
            end
            if (cfg_rd_en) begin
                last_en_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    note_fail("rd_unexpected");
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_addr", 32'(cfg_rd_addr), 32'(r));
                end
            end
            if (host_ack) begin
                if (exp_ack.size() == 0) begin
                    note_fail("ack_unexpected");
                end else begin
                    k = exp_ack.pop_front();
                    check("ack_err", 32'(host_err), 32'(k.err));
                    check("ack_rdata", 32'(host_rdata), 32'(k.rdata));
                    check("ack_init_done", 32'(init_done), 32'd1);
                    if (k.lat != 0) check("ack_latency", 32'(cyc - last_en_cyc), 32'(k.lat));
                end
            end
        end
    end

    task automatic push_wr(input logic [2:0] a, input logic [8:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_ack(input logic err, input logic [8:0] rd, input logic [7:0] l);
        ack_t k;
        k.err = err;
        k.rdata = rd;
        k.lat = l;
        exp_ack.push_back(k);
    endtask

    task automatic push_entry(input logic [2:0] a, input logic [8:0] d);
        push_wr(a, d);
`ifdef ADC_SEQ_VERIFY_EN
        exp_rd.push_back(a);
`endif
    endtask

    task automatic push_init();
        push_entry(3'd0, 9'h1A5);
        push_entry(3'd1, 9'h0F0);
        push_entry(3'd2, 9'h003);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(init_done), 32'd1);
    endtask

    task automatic drained(input string name);
        @(negedge clk);
        check(name, 32'(exp_wr.size() + exp_rd.size() + exp_ack.size()), 32'd0);
    endtask

    task automatic pulse_reinit();
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
    endtask

    task automatic host_op(input bit we, input logic [2:0] a, input logic [8:0] d);
        int n = 0;
        host_we = we;
        host_addr = a;
        host_wdata = d;
        host_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!host_ack && n < 600);
        check("host_ack_seen", 32'(host_ack), 32'd1);
        host_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        reset_n = 1'b0;
        reinit = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);

        push_init();
        reset_n = 1'b1;
        wait_init("init_done_first");
        check("init_error_first", 32'(init_error), 32'd0);
        drained("drain_init");

        exp_rd.push_back(3'd5);
        push_ack(1'b0, 9'h155, 8'd0);
        host_op(1'b0, 3'd5, 9'h000);
        drained("drain_read5");

        push_wr(3'd4, 9'h0AA);
        push_ack(1'b0, 9'h155, 8'd0);
        host_op(1'b1, 3'd4, 9'h0AA);
        exp_rd.push_back(3'd4);
        push_ack(1'b0, 9'h0AA, 8'd0);
        host_op(1'b0, 3'd4, 9'h000);
        drained("drain_wr_rd4");

        drop = 1'b1;
        push_wr(3'd6, 9'h111);
        push_ack(1'b1, 9'h0AA, 8'd64);
        host_op(1'b1, 3'd6, 9'h111);
        drop = 1'b0;
        drained("drain_timeout");

        push_wr(3'd3, 9'h07E);
        push_ack(1'b0, 9'h0AA, 8'd0);
        push_init();
        exp_rd.push_back(3'd3);
        push_ack(1'b0, 9'h07E, 8'd0);
        fork
            host_op(1'b1, 3'd3, 9'h07E);
            begin
                int m;
                m = 0;
                while (!cfg_wr_en && m < 100) begin
                    @(negedge clk);
                    m++;
                end
                @(negedge clk);
                pulse_reinit();
            end
        join
        host_we = 1'b0;
        host_addr = 3'd3;
        host_req = 1'b1;
        repeat (2) @(negedge clk);
        check("reinit_clears_done", 32'(init_done), 32'd0);
        host_op(1'b0, 3'd3, 9'h000);
        check("reinit_error", 32'(init_error), 32'd0);
        drained("drain_reinit");

        base = wr_seen;
        push_entry(3'd0, 9'h1A5);
        push_wr(3'd1, 9'h0F0);
        pulse_reinit();
        n = 0;
        while (wr_seen < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_init_wait", 32'(wr_seen - base), 32'd2);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_queue_empty", 32'(exp_wr.size() + exp_rd.size()), 32'd0);
        push_init();
        reset_n = 1'b1;
        wait_init("init_done_after_reset");
        check("init_error_after_reset", 32'(init_error), 32'd0);
        drained("drain_reset");

`ifdef ADC_SEQ_VERIFY_EN
        bad_base = bad_seen;
        bad_limit = 2;
        push_entry(3'd0, 9'h1A5);
        for (int i = 0; i < 3; i++) push_entry(3'd1, 9'h0F0);
        push_entry(3'd2, 9'h003);
        pulse_reinit();
        wait_init("init_done_retry");
        check("init_error_retry", 32'(init_error), 32'd0);
        drained("drain_retry");

        bad_base = bad_seen;
        bad_limit = 100;
        push_entry(3'd0, 9'h1A5);
        for (int i = 0; i < 3; i++) push_entry(3'd1, 9'h0F0);
        push_entry(3'd2, 9'h003);
        pulse_reinit();
        wait_init("init_done_exhaust");
        check("init_error_exhaust", 32'(init_error), 32'd1);
        drained("drain_exhaust");
        bad_limit = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
